cp0_timer: RTL
==============

# cp0_timer

CP0 Count/timer-interrupt unit. Holds the 32-bit Count register, advances it at the configured rate, and compares it against the Compare register value driven by cp0_Compare. On a match it raises the sticky timer-interrupt flag (Cause.TI / IP7). The flag is cleared when software writes Compare through mtc0. It sits beside cp0_Compare in the CP0 block, feeding the interrupt logic and the mfc0 read mux.

## Interface
- No parameters; constants come from defines.vh.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mtc0_we  in  1  committed mtc0 write strobe, already qualified by the pipeline.
- cp0_addr  in  8  CP0 address {rd[4:0], sel[2:0]}.
- mtc0_data  in  32  mtc0 write data.
- cp0_Compare_data  in  32  current Compare value from cp0_Compare.
- cp0_Count_data  out  32  Count register, to the mfc0 read mux.
- timer_int  out  1  sticky timer-interrupt flag, to Cause.TI and IP7.

## Operation
- Registers: count[31:0], tick (1 bit, only when halving is enabled), ti (1 bit).
- Reset (rst_n low, asynchronous): count = `Count_ini (32'h0), tick = 0, ti = 0, so cp0_Count_data = 0 and timer_int = 0.
- Count write (count_wr): mtc0_we && cp0_addr == `cp0addr_Count.
  - Next edge: count <= mtc0_data and tick <= 0.
  - This is not an increment, so it never sets ti, even if mtc0_data equals Compare.
- Compare write (cmp_wr): mtc0_we && cp0_addr == `cp0addr_Compare.
  - Next edge: ti <= 0.
  - The Compare register itself is stored in cp0_Compare, not here.
- Increment event inc: asserted on a cycle with no count_wr and tick == 1 (or every such cycle when halving is disabled).
  - count <= count + 1, modulo 2^32: 32'hFFFF_FFFF wraps to 0 with no carry-out and no flag.
- Match: on an inc cycle, if count + 1 == cp0_Compare_data, then ti <= 1.
  - ti stays 1 until cmp_wr or reset; further matches have no additional effect.
- Priority within one cycle:
  - cmp_wr clear beats a simultaneous match set, so ti = 0.
  - count_wr beats inc.
  - Writes to any other address are ignored.
- timer_int = ti, driven directly from the register with no combinational path from the inputs.

## Timing
- Count write: visible on cp0_Count_data 1 cycle after the mtc0_we edge.
  - With halving enabled, the first increment after the write happens 2 cycles later.
- Match: timer_int rises in the same edge that count takes the matching value. Latency is 1 cycle from the inc cycle.
- Compare write: timer_int falls 1 cycle after cmp_wr.
  - If the new Compare equals count + 1 on an inc cycle in that same cycle, the clear wins. The next match occurs after a full 2^32 increments.
- Reset mid-operation: all state clears immediately and asynchronously. Count restarts at 0 and tick at 0 after rst_n deasserts.
- The match is evaluated only on increments, so Count == Compare == 0 straight out of reset does not raise timer_int.

## Configuration
- COUNT_HALF_RATE_EN
  - Defined: tick toggles every cycle, and Count advances only on cycles where tick == 1, i.e. every other clk (MIPS32 rate). tick clears on reset and on count_wr.
  - Undefined: the tick register is absent and Count advances every clk with no count_wr.
  - All other behaviour is identical in both builds.

## Structure
- defines.vh (shared with cp0_Compare and the CP0 read mux) holds:
  - `cp0addr_Count = 8'h48 (rd 9, sel 0)
  - `cp0addr_Compare = 8'h58 (rd 11, sel 0)
  - `Count_ini = 32'h0
  - the COUNT_HALF_RATE_EN define
- Flat module with no sub-module. The tick divider is a single flop and does not warrant its own block.

## Test plan
- Reset release with cp0_Compare_data = 0 -> timer_int stays 0 for 10 cycles; Count = 0,1,2,… (half-rate: 0,0,1,1,2,…).
- mtc0 Count = 32'h0000_0010 with Compare = 32'h0000_0013 -> timer_int rises when Count becomes 32'h13 (3 increments after the write) and stays 1 for 20 more cycles.
- With timer_int = 1, mtc0 Compare = 32'h100 -> timer_int = 0 one cycle later; Count continues unaffected.
- mtc0 Count = 32'hFFFF_FFFE, Compare = 32'h0000_0000 -> Count passes FFFF_FFFF and wraps to 0; timer_int rises exactly at the wrap.
- Compare write in the same cycle as a matching increment -> timer_int remains 0.
- mtc0 Count = Compare = 32'h55 -> no interrupt. Assert rst_n low mid-count -> Count = 0 and timer_int = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_timer_pkg.sv
// rtl/cp0_timer_pkg.sv - CP0 Count/timer constants: register addresses and reset value.
package cp0_timer_pkg;

    localparam logic [7:0]  CP0ADDR_COUNT   = 8'h48;   // rd 9,  sel 0
    localparam logic [7:0]  CP0ADDR_COMPARE = 8'h58;   // rd 11, sel 0
    localparam logic [31:0] COUNT_INI       = 32'h0;

    function automatic logic is_addr(input logic we, input logic [7:0] addr,
                                     input logic [7:0] target);
        return we && (addr == target);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count register with sticky Compare-match timer interrupt.
// Optional COUNT_HALF_RATE_EN: Count advances every other clk via a tick flop.
module cp0_timer
    import cp0_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [31:0] cp0_Compare_data,
    output logic [31:0] cp0_Count_data,
    output logic        timer_int
);

    logic [31:0] r_count;
    logic        r_ti;
    logic        w_count_wr;
    logic        w_cmp_wr;
    logic        w_inc;
    logic [31:0] w_count_next;

    assign w_count_wr   = is_addr(mtc0_we, cp0_addr, CP0ADDR_COUNT);
    assign w_cmp_wr     = is_addr(mtc0_we, cp0_addr, CP0ADDR_COMPARE);
    assign w_count_next = r_count + 32'd1;

`ifdef COUNT_HALF_RATE_EN
    logic r_tick;

    // Restarting the divider on a Count write gives a full period before the first increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
        end else if (w_count_wr) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
        end
    end

    assign w_inc = !w_count_wr && r_tick;
`else
    assign w_inc = !w_count_wr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= COUNT_INI;
        end else if (w_count_wr) begin
            r_count <= mtc0_data;
        end else if (w_inc) begin
            r_count <= w_count_next;
        end
    end

    // Match is judged only on increments, so a Count write equal to Compare never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ti <= 1'b0;
        end else if (w_cmp_wr) begin
            r_ti <= 1'b0;
        end else if (w_inc && (w_count_next == cp0_Compare_data)) begin
            r_ti <= 1'b1;
        end
    end

    assign cp0_Count_data = r_count;
    assign timer_int      = r_ti;

endmodule
